// File: rtl/block_warp_looper.sv
// Expands one accepted block offset into its warps, issued in order; counts in-order retirements.
// Latency: src ack -> first dst_rdy 1 cycle; wdone_dval -> blkdone_dval 1 cycle (registered pulse).
// Backpressure: dst_ack low holds the current warp stable; src_ack only in IDLE, so one bubble per block.
module block_warp_looper #(
  parameter  int WBW      = 16,
  parameter  int VDIM     = 2,
  parameter  int MAX_WARP = 16,
  localparam int CW       = $clog2(MAX_WARP + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           src_rdy,
  output logic           src_ack,
  input  logic [WBW-1:0] i_bofs [VDIM],
  input  logic [CW-1:0]  i_warp_cnt,
  output logic           dst_rdy,
  input  logic           dst_ack,
  output logic [WBW-1:0] o_bofs [VDIM],
  output logic [CW-1:0]  o_warp_id,
  output logic           o_islast,
  input  logic           wdone_dval,
  output logic           blkdone_dval
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [WBW-1:0] bofs_q [VDIM];
  logic [WBW-1:0] bofs_d [VDIM];
  logic [CW-1:0]  wid_q, wid_d;
  logic [CW-1:0]  done_q, done_d;
  logic           blkdone_q, blkdone_d;
  logic [CW-1:0]  last_id;

  // Warp count is static for the life of a block, so the last index is a simple decrement.
  assign last_id  = i_warp_cnt - CW'(1);
  assign o_islast = (wid_q == last_id);
  assign src_ack  = (state_q == IDLE) && src_rdy;
  assign dst_rdy  = (state_q == ISSUE);
  assign o_bofs   = bofs_q;
  assign o_warp_id    = wid_q;
  assign blkdone_dval = blkdone_q;

  // Issue FSM: accept a block in IDLE, then walk warp ids until the last one is taken.
  always_comb begin
    state_d = state_q;
    bofs_d  = bofs_q;
    wid_d   = wid_q;
    case (state_q)
      IDLE: begin
        if (src_rdy) begin
          bofs_d  = i_bofs;
          wid_d   = '0;
          state_d = ISSUE;
        end
      end
      default: begin
        if (dst_ack) begin
          if (o_islast) begin
            state_d = IDLE;
          end else begin
            wid_d = wid_q + CW'(1);
          end
        end
      end
    endcase
  end

  // Retirement counter runs independently of issue; completions may lag by whole blocks.
  always_comb begin
    done_d    = done_q;
    blkdone_d = 1'b0;
    if (wdone_dval) begin
      if (done_q == last_id) begin
        done_d    = '0;
        blkdone_d = 1'b1;
      end else begin
        done_d = done_q + CW'(1);
      end
    end
  end

  // State registers; reset drops any in-flight block and pending completions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      bofs_q    <= '{default: '0};
      wid_q     <= '0;
      done_q    <= '0;
      blkdone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bofs_q    <= bofs_d;
      wid_q     <= wid_d;
      done_q    <= done_d;
      blkdone_q <= blkdone_d;
    end
  end

endmodule

// File: tb/tb_block_warp_looper.sv
// Directed bench for block_warp_looper: issue order, backpressure, turnaround, lagging retirement, reset.
// Latency: checks first warp 1 cycle after src ack and blkdone 1 cycle after the closing wdone pulse.
// Backpressure: dst_ack is only raised while dst_rdy is high; stalls must hold warp id and offset.
module tb_block_warp_looper;
  localparam int WBW      = 16;
  localparam int VDIM     = 2;
  localparam int MAX_WARP = 16;
  localparam int CW       = $clog2(MAX_WARP + 1);

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           src_rdy;
  logic           src_ack;
  logic [WBW-1:0] i_bofs [VDIM];
  logic [CW-1:0]  i_warp_cnt;
  logic           dst_rdy;
  logic           dst_ack;
  logic [WBW-1:0] o_bofs [VDIM];
  logic [CW-1:0]  o_warp_id;
  logic           o_islast;
  logic           wdone_dval;
  logic           blkdone_dval;

  int n_tests = 0;
  int n_fail  = 0;
  int outstanding = 0;

  block_warp_looper #(.WBW(WBW), .VDIM(VDIM), .MAX_WARP(MAX_WARP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .src_rdy(src_rdy), .src_ack(src_ack), .i_bofs(i_bofs), .i_warp_cnt(i_warp_cnt),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_bofs(o_bofs), .o_warp_id(o_warp_id),
    .o_islast(o_islast), .wdone_dval(wdone_dval), .blkdone_dval(blkdone_dval)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // A retirement is legal only if some warp is outstanding, counting one issuing this very cycle.
  always @(posedge i_clk or negedge i_rst_n) begin : wdone_guard
    int iss;
    if (!i_rst_n) begin
      outstanding <= 0;
    end else begin
      iss = (dst_rdy && dst_ack) ? 1 : 0;
      if (wdone_dval) chk("wdone_legal", 32'(outstanding + iss > 0), 32'd1);
      outstanding <= outstanding + iss - (wdone_dval ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input logic [CW-1:0] wc);
    i_rst_n = 1'b0; src_rdy = 1'b0; dst_ack = 1'b0; wdone_dval = 1'b0;
    i_warp_cnt = wc; i_bofs[0] = '0; i_bofs[1] = '0;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Present one block, take every warp with dst_ack high, check id/islast/offset each cycle.
  task automatic issue_block(input int b0, input int b1, input int wc);
    int waited = 0;
    tick();
    src_rdy = 1'b1; i_bofs[0] = WBW'(b0); i_bofs[1] = WBW'(b1);
    @(negedge i_clk);
    while (!src_ack && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
    chk("src_ack", 32'(src_ack), 32'd1);
    chk("rdy_in_ack_cycle", 32'(dst_rdy), 32'd0);
    tick();
    src_rdy = 1'b0;
    dst_ack = 1'b1;
    for (int i = 0; i < wc; i++) begin
      @(negedge i_clk);
      chk("dst_rdy", 32'(dst_rdy), 32'd1);
      chk("warp_id", 32'(o_warp_id), 32'(i));
      chk("islast", 32'(o_islast), 32'(i == wc - 1));
      chk("bofs0", 32'(o_bofs[0]), 32'(b0));
      chk("bofs1", 32'(o_bofs[1]), 32'(b1));
      tick();
    end
    dst_ack = 1'b0;
    @(negedge i_clk);
    chk("rdy_drop", 32'(dst_rdy), 32'd0);
  endtask

  // n separate retirement pulses from done_cnt = 0; blkdone expected the cycle after every wc-th.
  task automatic pulses(input int n, input int wc, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      wdone_dval = 1'b1;
      tick();
      wdone_dval = 1'b0;
      @(negedge i_clk);
      chk(tag, 32'(blkdone_dval), 32'((k + 1) % wc == 0));
    end
    @(negedge i_clk);
    chk({tag, "_tail"}, 32'(blkdone_dval), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int exp_id;
    int cyc;
    i_rst_n = 1'b0; src_rdy = 1'b0; dst_ack = 1'b0; wdone_dval = 1'b0;
    i_warp_cnt = CW'(4); i_bofs[0] = WBW'(8); i_bofs[1] = WBW'(16);

    // Reset state, observed while reset is still held.
    #12;
    chk("rst_dst_rdy", 32'(dst_rdy), 32'd0);
    chk("rst_src_ack", 32'(src_ack), 32'd0);
    chk("rst_bofs0", 32'(o_bofs[0]), 32'd0);
    chk("rst_bofs1", 32'(o_bofs[1]), 32'd0);
    chk("rst_warp_id", 32'(o_warp_id), 32'd0);
    chk("rst_blkdone", 32'(blkdone_dval), 32'd0);

    // Basic: 4 warps of {8,16}, then 4 retirements give one blkdone.
    do_reset(CW'(4));
    issue_block(8, 16, 4);
    pulses(4, 4, "basic_blkdone");

    // Backpressure: 30% random accept, ids must advance only on accept.
    do_reset(CW'(5));
    tick();
    src_rdy = 1'b1; i_bofs[0] = WBW'(3); i_bofs[1] = WBW'(7);
    @(negedge i_clk);
    chk("bp_src_ack", 32'(src_ack), 32'd1);
    tick();
    src_rdy = 1'b0;
    exp_id = 0;
    cyc = 0;
    while (exp_id < 5 && cyc < 300) begin
      @(negedge i_clk);
      cyc++;
      if (dst_rdy) begin
        chk("bp_id", 32'(o_warp_id), 32'(exp_id));
        chk("bp_bofs0", 32'(o_bofs[0]), 32'd3);
        chk("bp_bofs1", 32'(o_bofs[1]), 32'd7);
        dst_ack = ($urandom_range(0, 99) < 30);
        if (dst_ack) exp_id++;
      end else begin
        dst_ack = 1'b0;
      end
    end
    tick();
    dst_ack = 1'b0;
    chk("bp_all_warps", 32'(exp_id), 32'd5);
    @(negedge i_clk);
    chk("bp_rdy_drop", 32'(dst_rdy), 32'd0);
    pulses(5, 5, "bp_blkdone");

    // Back-to-back single-warp blocks {0,0},{4,0},{8,0}: src_ack every 2 cycles.
    do_reset(CW'(1));
    src_rdy = 1'b1; i_bofs[0] = WBW'(0); i_bofs[1] = WBW'(0);
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      chk("b2b_src_ack", 32'(src_ack), 32'(c % 2 == 0));
      if (c % 2 == 1) begin
        chk("b2b_dst_rdy", 32'(dst_rdy), 32'd1);
        chk("b2b_bofs0", 32'(o_bofs[0]), 32'(4 * (c / 2)));
        chk("b2b_islast", 32'(o_islast), 32'd1);
      end
      dst_ack = dst_rdy;
      tick();
      if (c % 2 == 0) begin
        i_bofs[0] = WBW'(4 * (c / 2 + 1));
        if (c == 4) src_rdy = 1'b0;
      end
    end
    dst_ack = 1'b0;
    pulses(3, 1, "b2b_blkdone");

    // Lagging completion: two 3-warp blocks issued, then 6 pulses, the 4th alongside a src_ack.
    do_reset(CW'(3));
    issue_block(1, 1, 3);
    issue_block(2, 2, 3);
    for (int k = 0; k < 6; k++) begin
      tick();
      wdone_dval = 1'b1;
      src_rdy = (k == 3);
      @(negedge i_clk);
      if (k == 3) chk("lag_src_ack", 32'(src_ack), 32'd1);
      tick();
      wdone_dval = 1'b0;
      src_rdy = 1'b0;
      @(negedge i_clk);
      chk("lag_blkdone", 32'(blkdone_dval), 32'(k == 2 || k == 5));
    end

    // Max count: 16 warps per block, two blocks to prove done_cnt wraps cleanly.
    do_reset(CW'(MAX_WARP));
    issue_block(1, 2, MAX_WARP);
    pulses(MAX_WARP, MAX_WARP, "max_blkdone_a");
    issue_block(3, 4, MAX_WARP);
    pulses(MAX_WARP, MAX_WARP, "max_blkdone_b");

    // Reset mid-block after warp 2 of 4, with two warps already retired.
    do_reset(CW'(4));
    src_rdy = 1'b1; i_bofs[0] = WBW'(5); i_bofs[1] = WBW'(6);
    @(negedge i_clk);
    chk("mid_src_ack", 32'(src_ack), 32'd1);
    tick();
    src_rdy = 1'b0;
    dst_ack = 1'b1;
    wdone_dval = 1'b1;
    tick();
    tick();
    wdone_dval = 1'b0;
    dst_ack = 1'b0;
    @(negedge i_clk);
    chk("mid_pre_id", 32'(o_warp_id), 32'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_dst_rdy", 32'(dst_rdy), 32'd0);
    chk("mid_warp_id", 32'(o_warp_id), 32'd0);
    chk("mid_bofs0", 32'(o_bofs[0]), 32'd0);
    chk("mid_bofs1", 32'(o_bofs[1]), 32'd0);
    chk("mid_blkdone", 32'(blkdone_dval), 32'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
    issue_block(9, 9, 4);
    pulses(4, 4, "mid_post_blkdone");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
